// File: rtl/alu_seq.sv
// alu_seq: registered 74181-compatible ALU slice chain with iterative unsigned multiply and optional divide.
// Define ALU_SEQ_DIV_EN to build the restoring divider for op=10; otherwise op=10 is a reserved op.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       aluf,
  input  logic             alumode,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   alu,
  output logic [WIDTH-1:0] q,
  output logic             aeqm,
  output logic             err
);

  localparam int unsigned NIB = WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH:0]   r_alu, w_alu_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_aeqm, w_aeqm_nxt;
  logic             r_err, w_err_nxt;

  logic [WIDTH-1:0] w_u, w_v, w_f;
  logic [4:0]       w_nsum;
  logic             w_carry;
  logic             w_sign;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;

  // 74181 slice: F = u plus v plus carry (arithmetic) or ~(u ^ v) (logic), nibble carry ripple
  always_comb begin
    w_u     = m | (a & {WIDTH{aluf[0]}}) | (~a & {WIDTH{aluf[1]}});
    w_v     = (m & a & {WIDTH{aluf[3]}}) | (m & ~a & {WIDTH{aluf[2]}});
    w_f     = '0;
    w_nsum  = '0;
    w_carry = cin0;
    for (int unsigned i = 0; i < NIB; i++) begin
      w_nsum = 5'(w_u[4*i +: 4]) + 5'(w_v[4*i +: 4]) + 5'(w_carry);
      w_f[4*i +: 4] = alumode ? ~(w_u[4*i +: 4] ^ w_v[4*i +: 4]) : w_nsum[3:0];
      w_carry = w_nsum[4];
    end
    // extra slice bit fed by the sign bits and the top nibble carry
    w_sign = alumode ? w_f[WIDTH-1] : (w_u[WIDTH-1] ^ w_v[WIDTH-1] ^ w_carry);
  end

  // shift-add multiply step: {hi, lo} holds partial product and remaining multiplier bits
  always_comb begin
    w_madd   = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_opnd});
    w_mul_hi = w_madd[WIDTH:1];
    w_mul_lo = {w_madd[0], r_lo[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic             r_is_div, w_is_div_nxt;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;

  // restoring divide step: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    w_trial  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_trial[WIDTH-1:0] - r_opnd;
    w_ge     = (w_trial >= {1'b0, r_opnd});
    w_div_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
    w_div_lo = {r_lo[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
    w_step_lo = r_is_div ? w_div_lo : w_mul_lo;
  end
`else
  always_comb begin
    w_step_hi = w_mul_hi;
    w_step_lo = w_mul_lo;
  end
`endif

  // next-state and datapath/output next values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_opnd_nxt  = r_opnd;
    w_alu_nxt   = r_alu;
    w_q_nxt     = r_q;
    w_aeqm_nxt  = r_aeqm;
    w_err_nxt   = r_err;
`ifdef ALU_SEQ_DIV_EN
    w_is_div_nxt = r_is_div;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            2'b00: begin
              w_alu_nxt   = {w_sign, w_f};
              w_q_nxt     = '0;
              w_aeqm_nxt  = &w_f;
              w_err_nxt   = 1'b0;
              w_state_nxt = S_FIN;
            end
            2'b01: begin
              w_hi_nxt    = '0;
              w_lo_nxt    = a;
              w_opnd_nxt  = m;
              w_cnt_nxt   = CNTW'(WIDTH);
              w_state_nxt = S_RUN;
`ifdef ALU_SEQ_DIV_EN
              w_is_div_nxt = 1'b0;
`endif
            end
`ifdef ALU_SEQ_DIV_EN
            2'b10: begin
              if (a == '0) begin
                w_alu_nxt   = {1'b0, m};
                w_q_nxt     = '1;
                w_aeqm_nxt  = 1'b0;
                w_err_nxt   = 1'b1;
                w_state_nxt = S_FIN;
              end else begin
                w_hi_nxt     = '0;
                w_lo_nxt     = m;
                w_opnd_nxt   = a;
                w_is_div_nxt = 1'b1;
                w_cnt_nxt    = CNTW'(WIDTH);
                w_state_nxt  = S_RUN;
              end
            end
`endif
            default: begin
              w_alu_nxt   = '0;
              w_q_nxt     = '0;
              w_aeqm_nxt  = 1'b0;
              w_err_nxt   = 1'b1;
              w_state_nxt = S_FIN;
            end
          endcase
        end
      end
      S_RUN: begin
        w_hi_nxt  = w_step_hi;
        w_lo_nxt  = w_step_lo;
        w_cnt_nxt = r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_FIN;
          w_aeqm_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
          if (r_is_div) begin
            w_q_nxt   = w_step_lo;
            w_alu_nxt = {1'b0, w_step_hi};
          end else begin
            w_q_nxt   = w_step_hi;
            w_alu_nxt = {1'b0, w_step_lo};
          end
`else
          w_q_nxt   = w_step_hi;
          w_alu_nxt = {1'b0, w_step_lo};
`endif
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_alu   <= '0;
      r_q     <= '0;
      r_aeqm  <= 1'b0;
      r_err   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_opnd  <= w_opnd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_alu   <= w_alu_nxt;
      r_q     <= w_q_nxt;
      r_aeqm  <= w_aeqm_nxt;
      r_err   <= w_err_nxt;
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= w_is_div_nxt;
`endif
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign alu  = r_alu;
  assign q    = r_q;
  assign aeqm = r_aeqm;
  assign err  = r_err;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CADR 74S181-slice ALU.
- Performs single-cycle 74181-equivalent functions across WIDTH bits with a 33rd-style sign bit.
- Adds iterative unsigned multiply and, optionally, divide, sequenced by an internal FSM with a start/busy/done handshake.
- Sits in the data path between the A/M memories and the output bus selector; microcode issues one operation per start.

Parameters:
- WIDTH, 32: operand width; must be a multiple of 4 and at least 8.
- CNTW, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  2  operation: 00 ALU function, 01 unsigned multiply, 10 unsigned divide, 11 reserved.
- aluf  in  4  74181 S inputs; used only for op=00.
- alumode  in  1  74181 M input; 1 selects logic, 0 selects arithmetic.
- cin0  in  1  carry-in, active-high; used only for op=00.
- a  in  WIDTH  B-side operand; multiplier for op=01, divisor for op=10.
- m  in  WIDTH  A-side operand; multiplicand for op=01, dividend for op=10.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- alu  out  WIDTH+1  result: function output, product low word, or remainder.
- q  out  WIDTH  product high word or quotient; 0 for op=00.
- aeqm  out  1  74181 A=B output: 1 iff alu[WIDTH-1:0] is all ones, op=00 only.
- err  out  1  error: divide by zero or reserved op.

Behaviour:
- Reset: busy=0, done=0, alu=0, q=0, aeqm=0, err=0, FSM=IDLE, counter=0. Reset mid-operation aborts it; no done pulse is produced.
- Operands and op are captured on the accepting edge. Later input changes do not affect the operation in progress.
- FSM states: IDLE, RUN, FIN.
  - IDLE + start, op=00: compute, register results, go to FIN.
  - IDLE + start, op=01: go to RUN with counter=WIDTH.
  - IDLE + start, op=10: go to RUN with counter=WIDTH; if a=0, go to FIN instead.
  - IDLE + start, op=11: go to FIN.
  - RUN: one iteration per cycle, counter decrements; at counter=1, go to FIN.
  - FIN: done=1 for that cycle, busy=0, then IDLE.
- busy=1 in RUN only; done=1 in FIN only. A start while busy is ignored and not queued.
- A start in FIN is ignored; the earliest new accept is the edge after done.
- Latency (edges from the accepting edge to the cycle where done=1):
  - op=00: 1.
  - op=01 and op=10: WIDTH+1.
  - divide by zero and reserved op: 1.
- op=00 (ALU function):
  - Exact 74181 function table with A=m, B=a, S=aluf, M=alumode, active-low internal carry equal to ~cin0.
  - Carry ripples across WIDTH/4 nibbles.
  - alu[WIDTH] = the same function applied to the sign bits m[WIDTH-1], a[WIDTH-1] with the carry out of the top nibble; this gives a (WIDTH+1)-bit sign-extended result.
  - Results: q=0, err=0, aeqm as defined above.
- op=01 (multiply):
  - Shift-add, unsigned, LSB-first over a.
  - Results: {q, alu[WIDTH-1:0]} = m*a (2*WIDTH bits); alu[WIDTH]=0, aeqm=0, err=0.
- op=10 (divide):
  - Restoring division, m / a.
  - Results: q = quotient, alu[WIDTH-1:0] = remainder, alu[WIDTH]=0, aeqm=0.
  - If a=0: err=1, q = all ones, alu = {1'b0, m}.
- op=11: err=1, alu=0, q=0.
- Outputs hold their last values until the next accepting edge, then update at FIN. alu, q, aeqm and err are valid in the done cycle and all later cycles until the next FIN.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- When defined: op=10 behaves as specified above.
- When undefined: no divider logic is synthesised. op=10 is treated as reserved: latency 1, err=1, alu=0, q=0.

Test Plan:
- Add, WIDTH=32: op=00, alumode=0, aluf=1001, cin0=0, m=5, a=3 -> done one edge after accept; alu=33'h0_0000_0008, aeqm=0, q=0.
- Compare: op=00, alumode=0, aluf=0110, cin0=0, m=a=32'h0000_1234 -> alu[31:0]=32'hFFFF_FFFF, aeqm=1. Repeat with a=32'h1235 -> aeqm=0.
- Multiply: op=01, m=32'hFFFF_FFFF, a=2 -> busy high for 32 cycles; done 33 edges after accept; q=1, alu=33'h0_FFFF_FFFE.
- Divide (ALU_SEQ_DIV_EN defined): m=100, a=7 -> done after 33 edges; q=14, alu=2, err=0. Then m=9, a=0 -> done after 1 edge; err=1, q=32'hFFFF_FFFF, alu=9.
- Handshake: start pulsed every cycle during a multiply -> exactly one done. Assert reset at iteration 10 of a multiply -> next cycle busy=0, alu=0, q=0, and no done pulse.
- WIDTH=8: op=00, add (aluf=1001), cin0=0, m=8'hFF, a=8'h01 -> alu=9'h000. With ALU_SEQ_DIV_EN undefined, op=10 -> err=1 after 1 edge.
